// File: rtl/fractal_pkg.sv
// Shared types for the fractal pixel pipeline: the per-pixel result word
// carried from the iteration engine to the colour/VGA side.
package fractal_pkg;

  localparam int DEFAULT_ITER_WIDTH = 6;
  localparam int DEFAULT_DEPTH      = 16;

  typedef struct packed {
    logic                          in_set;
    logic [DEFAULT_ITER_WIDTH-1:0] iter;
  } pixel_result_t;

  function automatic pixel_result_t make_result(input logic                          in_set,
                                                input logic [DEFAULT_ITER_WIDTH-1:0] iter);
    pixel_result_t r;
    r.in_set = in_set;
    r.iter   = iter;
    return r;
  endfunction

endpackage

// File: rtl/pixel_result_fifo_if.sv
// Write/read handshake bundle between the iteration engine, the result FIFO
// and the colour stage. The FIFO side uses the slave modport.
interface pixel_result_fifo_if;
  import fractal_pkg::*;

  logic          wr_valid;
  logic          wr_ready;
  pixel_result_t wr_data;
  logic          rd_valid;
  logic          rd_ready;
  pixel_result_t rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/pixel_result_fifo_mem.sv
// Result storage for pixel_result_fifo: DEPTH x WIDTH array with one
// synchronous write port and one asynchronous read port.
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; validity is tracked by
  // the pointers and level, so resetting the array would only cost a reset tree.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_result_fifo.sv
// First-word fall-through FIFO buffering engine results for the colour stage.
// Define PIXEL_FIFO_STATS_EN to build the saturating underrun counter.
module pixel_result_fifo
  import fractal_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ITER_WIDTH  = DEFAULT_ITER_WIDTH,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pixel_result_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic [15:0]            underrun_cnt
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int DATA_W = ITER_WIDTH + 1;

  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_LEVEL);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic              push;
  logic              pop;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Handshake flags depend only on the registered level, so no ready/valid
  // combinational path crosses the FIFO.
  assign bus.wr_ready = (level != FULL_LVL);
  assign bus.rd_valid = (level != '0);

  assign push   = bus.wr_valid && bus.wr_ready;
  assign pop    = bus.rd_valid && bus.rd_ready;
  assign mem_we = push && !flush && !rst;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level       <= level_nxt;
      almost_full <= (level_nxt >= AFULL_LVL);
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (DATA_W'(bus.wr_data)),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign bus.rd_data = pixel_result_t'(mem_rdata);

`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0] underrun_q;

  // Counts cycles the consumer wanted a pixel that was not there; flush
  // cycles are excluded because the frame is being restarted anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q <= '0;
    end else if (bus.rd_ready && !bus.rd_valid && !flush && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule
